// File: rtl/avmm_scratch_ram.sv
// Avalon-MM scratch RAM: zero-fill on reset, fixed read latency 2, byte-lane writes.
// Optional access counters at 0x8000_0000/0x8000_0004 when AVMM_SCRATCH_STATS_EN is defined.
module avmm_scratch_ram #(
  parameter int          ADDR_BITS = 8,
  parameter logic [31:0] FILL_WORD = 32'hDEADBEEF
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [31:0] avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        avs_waitrequest,
  output logic        busy
);

  localparam int                   DEPTH    = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] CNT_LAST = {ADDR_BITS{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [ADDR_BITS-1:0] clr_cnt_r;
  logic                 waitreq_r;
  logic                 busy_r;

  logic [ADDR_BITS-1:0] word_idx_s;
  logic                 mapped_s;
  logic                 acc_rd_s;
  logic                 acc_wr_s;

  logic [31:0]          mem_r [DEPTH];
  logic [31:0]          ram_q_r;
  logic                 ram_we_s;
  logic [3:0]           ram_be_s;
  logic [ADDR_BITS-1:0] ram_addr_s;
  logic [31:0]          ram_wdata_s;

  logic                 s1_vld_r;
  logic                 s1_mapped_r;
  logic [ADDR_BITS-1:0] s1_idx_r;
  logic                 rdv_r;
  logic [31:0]          rdata_r;
  logic [31:0]          rd_sel_s;
  logic                 unused_s;

  assign word_idx_s = avs_address[ADDR_BITS+1:2];
  assign mapped_s   = (avs_address[31:ADDR_BITS+2] == {(30-ADDR_BITS){1'b0}});

  // Next-state and RAM port steering: INIT owns the port for the zero fill
  always_comb begin
    state_nxt_s = state_r;
    acc_rd_s    = 1'b0;
    acc_wr_s    = 1'b0;
    ram_we_s    = 1'b0;
    ram_be_s    = 4'b0000;
    ram_addr_s  = word_idx_s;
    ram_wdata_s = avs_writedata;
    case (state_r)
      ST_INIT: begin
        ram_we_s    = 1'b1;
        ram_be_s    = 4'b1111;
        ram_addr_s  = clr_cnt_r;
        ram_wdata_s = 32'h0000_0000;
        if (clr_cnt_r == CNT_LAST) begin
          state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_READY: begin
        state_nxt_s = ST_READY;
        acc_wr_s    = avs_write;
        acc_rd_s    = avs_read & ~avs_write;
        ram_we_s    = avs_write & mapped_s;
        ram_be_s    = avs_byteenable;
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  // State register, clear counter and status outputs aligned with the state
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_r   <= ST_INIT;
      clr_cnt_r <= {ADDR_BITS{1'b0}};
      waitreq_r <= 1'b1;
      busy_r    <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      if (state_r == ST_INIT) begin
        clr_cnt_r <= clr_cnt_r + ADDR_BITS'(1);
      end else begin
        clr_cnt_r <= {ADDR_BITS{1'b0}};
      end
      waitreq_r <= (state_nxt_s == ST_INIT);
      busy_r    <= (state_nxt_s == ST_INIT);
    end
  end

  // Single-port block RAM, read-first, per-byte write enables
  always_ff @(posedge clk_clk) begin
    if (ram_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be_s[b]) begin
          mem_r[ram_addr_s][8*b +: 8] <= ram_wdata_s[8*b +: 8];
        end
      end
    end
    ram_q_r <= mem_r[ram_addr_s];
  end

`ifdef AVMM_SCRATCH_STATS_EN
  localparam logic [29:0] STAT_RD_WORD = 30'h2000_0000;
  localparam logic [29:0] STAT_WR_WORD = 30'h2000_0001;

  logic [31:0] rd_cnt_r;
  logic [31:0] wr_cnt_r;
  logic        s1_stat_hit_r;
  logic [31:0] s1_stat_data_r;

  // Access counters; wrap naturally at 2^32
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rd_cnt_r <= 32'h0000_0000;
      wr_cnt_r <= 32'h0000_0000;
    end else begin
      if (acc_rd_s) begin
        rd_cnt_r <= rd_cnt_r + 32'h0000_0001;
      end else begin
        rd_cnt_r <= rd_cnt_r;
      end
      if (acc_wr_s) begin
        wr_cnt_r <= wr_cnt_r + 32'h0000_0001;
      end else begin
        wr_cnt_r <= wr_cnt_r;
      end
    end
  end

  // Counter value is snapshotted at acceptance, so a counter read excludes itself
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s1_stat_hit_r  <= 1'b0;
      s1_stat_data_r <= 32'h0000_0000;
    end else begin
      s1_stat_hit_r  <= (avs_address[31:2] == STAT_RD_WORD) ||
                        (avs_address[31:2] == STAT_WR_WORD);
      if (avs_address[31:2] == STAT_WR_WORD) begin
        s1_stat_data_r <= wr_cnt_r;
      end else begin
        s1_stat_data_r <= rd_cnt_r;
      end
    end
  end

  // Read data source select for the output stage
  always_comb begin
    rd_sel_s = FILL_WORD;
    if (s1_stat_hit_r) begin
      rd_sel_s = s1_stat_data_r;
    end else if (s1_mapped_r) begin
      rd_sel_s = ram_q_r;
    end else begin
      rd_sel_s = FILL_WORD;
    end
  end
`else
  // Read data source select for the output stage
  always_comb begin
    rd_sel_s = FILL_WORD;
    if (s1_mapped_r) begin
      rd_sel_s = ram_q_r;
    end else begin
      rd_sel_s = FILL_WORD;
    end
  end
`endif

  // Two-stage read pipeline; readdata holds between strobes
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s1_vld_r    <= 1'b0;
      s1_mapped_r <= 1'b0;
      s1_idx_r    <= {ADDR_BITS{1'b0}};
      rdv_r       <= 1'b0;
      rdata_r     <= 32'h0000_0000;
    end else begin
      s1_vld_r    <= acc_rd_s;
      s1_mapped_r <= mapped_s;
      s1_idx_r    <= word_idx_s;
      rdv_r       <= s1_vld_r;
      if (s1_vld_r) begin
        rdata_r <= rd_sel_s;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  // Byte offset bits and the stage-1 index are carried only for visibility
  assign unused_s = ^{avs_address[1:0], s1_idx_r};

  assign avs_readdata      = rdata_r;
  assign avs_readdatavalid = rdv_r;
  assign avs_waitrequest   = waitreq_r;
  assign busy              = busy_r;

endmodule

// File: tb/tb_avmm_scratch_ram.sv
// Scoreboard bench for avmm_scratch_ram (default ADDR_BITS=8); expected read
// data and arrival cycle are queued at issue and checked at readdatavalid.
module tb_avmm_scratch_ram;

  localparam int          AB   = 8;
  localparam logic [31:0] FILL = 32'hDEADBEEF;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [31:0] avs_address = 32'h0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'h0;
  logic [3:0]  avs_byteenable = 4'h0;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_waitrequest;
  logic        busy;

  avmm_scratch_ram dut (
    .clk_clk          (clk_clk),
    .reset_reset      (reset_reset),
    .avs_address      (avs_address),
    .avs_read         (avs_read),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .avs_byteenable   (avs_byteenable),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .avs_waitrequest  (avs_waitrequest),
    .busy             (busy)
  );

  always #5 clk_clk = ~clk_clk;

  int unsigned cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl [1 << AB];
  logic [31:0] mdl_rd_cnt = 32'h0;
  logic [31:0] mdl_wr_cnt = 32'h0;
  logic [31:0] last_rd = 32'h0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] addr);
`ifdef AVMM_SCRATCH_STATS_EN
    if (addr[31:2] == 30'h2000_0000) return mdl_rd_cnt;
    if (addr[31:2] == 30'h2000_0001) return mdl_wr_cnt;
`endif
    if (addr[31:AB+2] == '0) return mdl[addr[AB+1:2]];
    return FILL;
  endfunction

  // Scoreboard monitor: one strobe per queued read, exactly on its due cycle
  always @(negedge clk_clk) begin
    exp_t e;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      check_val("rdv", {31'h0, avs_readdatavalid}, 32'h1);
      if (avs_readdatavalid) begin
        check_val("rdata", avs_readdata, e.data);
        last_rd = e.data;
      end
    end else if (avs_readdatavalid) begin
      check_val("unexp_rdv", {31'h0, avs_readdatavalid}, 32'h0);
    end
  end

  task automatic bus_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    exp_t        e;
    logic [31:0] cur;
    int unsigned k;
    avs_read       = rd;
    avs_write      = wr;
    avs_address    = addr;
    avs_writedata  = wdata;
    avs_byteenable = be;
    @(posedge clk_clk);
    #1;
    k = cyc;
    if (wr) begin
      if (addr[31:AB+2] == '0) begin
        cur = mdl[addr[AB+1:2]];
        for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = wdata[8*b +: 8];
        mdl[addr[AB+1:2]] = cur;
      end
      mdl_wr_cnt = mdl_wr_cnt + 32'h1;
    end else if (rd) begin
      e.data = exp_read(addr);
      e.due  = k + 1;
      sb_q.push_back(e);
      mdl_rd_cnt = mdl_rd_cnt + 32'h1;
    end
  endtask

  task automatic idle();
    avs_read  = 1'b0;
    avs_write = 1'b0;
    @(posedge clk_clk);
    #1;
  endtask

  task automatic reset_and_init();
    int n;
    avs_read    = 1'b0;
    avs_write   = 1'b0;
    reset_reset = 1'b1;
    sb_q.delete();
    @(posedge clk_clk);
    #1;
    reset_reset = 1'b0;
    for (int i = 0; i < (1 << AB); i++) mdl[i] = 32'h0;
    mdl_rd_cnt = 32'h0;
    mdl_wr_cnt = 32'h0;
    last_rd    = 32'h0;
    @(negedge clk_clk);
    check_val("rst_waitreq", {31'h0, avs_waitrequest}, 32'h1);
    check_val("rst_busy", {31'h0, busy}, 32'h1);
    check_val("rst_rdv", {31'h0, avs_readdatavalid}, 32'h0);
    check_val("rst_rdata", avs_readdata, 32'h0);
    n = 0;
    while (avs_waitrequest === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk_clk);
    end
    check_val("init_len", n, 32'd256);
    check_val("ready_busy", {31'h0, busy}, 32'h0);
    @(posedge clk_clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_and_init();

    // Last word cleared by INIT
    bus_op(1'b1, 1'b0, 32'h0000_03FC, 32'h0, 4'hF);
    idle();

    // Byte-lane merge, read right after write
    bus_op(1'b0, 1'b1, 32'h0000_0010, 32'h1122_3344, 4'b1111);
    bus_op(1'b0, 1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0101);
    bus_op(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
    idle();

    // Back-to-back reads
    for (int i = 0; i < 4; i++) bus_op(1'b0, 1'b1, 32'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) bus_op(1'b1, 1'b0, 32'(i * 4), 32'h0, 4'hF);
    idle(); idle(); idle();
    check_val("rdata_hold", avs_readdata, last_rd);

    // Unmapped read, read+write collision, zero byteenable, unmapped write
    bus_op(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
    bus_op(1'b1, 1'b1, 32'h0000_0014, 32'h55AA_5AA5, 4'hF);
    bus_op(1'b1, 1'b0, 32'h0000_0014, 32'h0, 4'hF);
    bus_op(1'b0, 1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'b0000);
    bus_op(1'b1, 1'b0, 32'h0000_0014, 32'h0, 4'hF);
    bus_op(1'b0, 1'b1, 32'h0000_0400, 32'h1234_5678, 4'hF);
    bus_op(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'hF);
    idle(); idle();

    // Random mix over a small window with occasional unmapped aliases
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      int          op;
      a  = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | 32'h0000_0400;
      op = $urandom_range(0, 3);
      if (op == 0) idle();
      else bus_op(op[1], op[0], a, $urandom, 4'($urandom_range(0, 15)));
    end
    idle(); idle(); idle();

    // Reset with a read in flight: strobe dropped, INIT restarts
    bus_op(1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'hF);
    reset_and_init();

    // Access counters (FILL_WORD when the feature is compiled out)
    bus_op(1'b0, 1'b1, 32'h0000_0020, 32'h0000_00A1, 4'hF);
    bus_op(1'b0, 1'b1, 32'h0000_0024, 32'h0000_00A2, 4'hF);
    bus_op(1'b0, 1'b1, 32'h0000_0028, 32'h0000_00A3, 4'hF);
    bus_op(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
    bus_op(1'b1, 1'b0, 32'h0000_0028, 32'h0, 4'hF);
    bus_op(1'b1, 1'b0, 32'h8000_0004, 32'h0, 4'hF);
    bus_op(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
    bus_op(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0000, 4'hF);
    bus_op(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
    bus_op(1'b1, 1'b0, 32'h8000_0004, 32'h0, 4'hF);
    repeat (4) idle();

    check_val("sb_drain", sb_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/avmm_scratch_ram.md
AVMM_SCRATCH_RAM -- requirements
Module: avmm_scratch_ram

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, word-address width of internal RAM (2^ADDR_BITS 32-bit words).
REQ-002 SHALL have parameter FILL_WORD, default 32'hDEADBEEF, read data returned for unmapped addresses.
REQ-003 SHALL have port clk_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port avs_address  input  32  byte address from Avalon-MM master; bits [1:0] ignored.
REQ-006 SHALL have port avs_read  input  1  read request.
REQ-007 SHALL have port avs_write  input  1  write request.
REQ-008 SHALL have port avs_writedata  input  32  write data.
REQ-009 SHALL have port avs_byteenable  input  4  byte lane enables, bit n = bits [8n+7:8n].
REQ-010 SHALL have port avs_readdata  output  32  read data, valid when avs_readdatavalid high.
REQ-011 SHALL have port avs_readdatavalid  output  1  one-cycle strobe per accepted read.
REQ-012 SHALL have port avs_waitrequest  output  1  high = request not accepted this cycle.
REQ-013 SHALL have port busy  output  1  high while in INIT state.

Function
REQ-014 SHALL implement two-state FSM: INIT, READY.
REQ-015 INIT: SHALL write 32'h0 to word index clr_cnt each cycle, clr_cnt counting 0..2^ADDR_BITS-1, then enter READY; duration exactly 2^ADDR_BITS cycles.
REQ-016 INIT: avs_waitrequest and busy SHALL be 1; no request accepted.
REQ-017 READY: avs_waitrequest and busy SHALL be 0; request accepted in any cycle avs_read or avs_write is high.
REQ-018 Word index = avs_address[31:2]; mapped iff avs_address[31:ADDR_BITS+2] == 0.
REQ-019 Accepted write to mapped word SHALL update only byte lanes with avs_byteenable bit set, effective at that clock edge; byteenable 4'b0000 leaves word unchanged.
REQ-020 Writes to unmapped words SHALL be ignored without error.
REQ-021 Accepted read SHALL produce avs_readdatavalid exactly 2 cycles after acceptance cycle (fixed latency 2), with RAM word or FILL_WORD if unmapped.
REQ-022 Back-to-back reads SHALL be accepted every cycle; readdatavalid strobes in order, one per read, no gaps added.
REQ-023 Read accepted the cycle after a write to the same word SHALL return the new data.
REQ-024 avs_read and avs_write both high: write SHALL be performed, read ignored (no readdatavalid).
REQ-025 avs_readdata SHALL hold its last value when avs_readdatavalid is 0.
REQ-026 Read pipeline SHALL be 2 stages of {valid, mapped, word index}; RAM inferable as synchronous single-port block RAM with byte enables.

Reset
REQ-027 Reset high at any cycle SHALL next cycle give: state INIT, clr_cnt 0, pipeline valid bits 0, avs_readdatavalid 0, avs_readdata 32'h0, avs_waitrequest 1, busy 1.
REQ-028 Reads in flight at reset SHALL be dropped (no readdatavalid); INIT SHALL restart from word 0 on reset mid-INIT.
REQ-029 While reset held, FSM SHALL remain at INIT with clr_cnt 0.

Configuration
REQ-030 Macro AVMM_SCRATCH_STATS_EN SHALL, when defined, add two read-only 32-bit counters at byte addresses 32'h8000_0000 (accepted reads) and 32'h8000_0004 (accepted writes), wrapping at 2^32, cleared by reset, readable with latency 2; writes to them ignored; these reads count themselves after the access.
REQ-031 Without AVMM_SCRATCH_STATS_EN, those addresses SHALL behave as unmapped (FILL_WORD) and no counter logic SHALL exist.

Verification
REQ-032 Reset 1 cycle, ADDR_BITS=8 -> waitrequest=1, busy=1 for exactly 256 cycles, then 0; read word 0xFF -> 32'h0.
REQ-033 Write 0x0000_0010 data 32'h11223344 be 4'b1111, then write same addr 32'hAABBCCDD be 4'b0101 -> read returns 32'h11BB33DD, readdatavalid 2 cycles after read.
REQ-034 Four back-to-back reads of words 0..3 holding 1,2,3,4 -> readdatavalid high 4 consecutive cycles starting 2 cycles after first read, data 1,2,3,4.
REQ-035 Read 32'h0000_0400 (unmapped) -> 32'hDEADBEEF; simultaneous read+write word 5 -> data written, no readdatavalid.
REQ-036 Issue read, assert reset next cycle -> no readdatavalid, waitrequest=1, INIT restarts.
REQ-037 With AVMM_SCRATCH_STATS_EN: after reset+INIT, 3 writes, 2 reads, read 32'h8000_0004 -> 3; read 32'h8000_0000 -> 3; without macro both return 32'hDEADBEEF.
